concat_mult_add_grad: RTL and testbench

- Backward-pass counterpart of the LSTM gate pre-activation unit (forward: out = W0*X + W1*h_in + b, fixed point).
- Per accepted sample, consumes the gate error delta with the forward operands (X, h_in, W0, W1).
- Per sample, emits back-propagated errors dx = W0*delta and dh = W1*delta.
- Across a sequence, accumulates weight and bias gradients dW0 += delta*X, dW1 += delta*h_in, db += delta, and presents them when the sequence ends.
- Sits between the gate-activation derivative stage and the weight-update / previous-timestep error path.

---
 rtl/concat_mult_add_grad_if.sv | 42 ++++
 rtl/concat_mult_add_grad.sv | 185 ++++++++++++++++++
 tb/tb_concat_mult_add_grad.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/concat_mult_add_grad_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : concat_mult_add_grad_if                                |
// | Brief   : Sample, error-output and gradient handshake bundle     |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
interface concat_mult_add_grad_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int COUNT_WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_last;
  logic [DATA_WIDTH-1:0]  delta;
  logic [DATA_WIDTH-1:0]  X;
  logic [DATA_WIDTH-1:0]  h_in;
  logic [DATA_WIDTH-1:0]  W0;
  logic [DATA_WIDTH-1:0]  W1;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  dx;
  logic [DATA_WIDTH-1:0]  dh;
  logic                   grad_valid;
  logic                   grad_ready;
  logic [ACC_WIDTH-1:0]   dW0;
  logic [ACC_WIDTH-1:0]   dW1;
  logic [ACC_WIDTH-1:0]   db;
  logic [COUNT_WIDTH-1:0] seq_len;
  logic                   ovf;

  modport master (
    output in_valid, in_last, delta, X, h_in, W0, W1, out_ready, grad_ready,
    input  in_ready, out_valid, dx, dh, grad_valid, dW0, dW1, db, seq_len, ovf
  );

  modport slave (
    input  in_valid, in_last, delta, X, h_in, W0, W1, out_ready, grad_ready,
    output in_ready, out_valid, dx, dh, grad_valid, dW0, dW1, db, seq_len, ovf
  );
endinterface
`default_nettype wire

// File: rtl/concat_mult_add_grad.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : concat_mult_add_grad                                   |
// | Brief   : LSTM gate pre-activation backward pass: per-sample     |
// |           dx/dh and per-sequence dW0/dW1/db accumulation.        |
// |           GRAD_SAT_EN selects clamping instead of wrapping.      |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module concat_mult_add_grad #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  concat_mult_add_grad_if.slave bus
);

  localparam int PW = 2 * DATA_WIDTH;
  // Sum width wide enough that no accumulate step can wrap internally
  localparam int SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;

`ifdef GRAD_SAT_EN
  localparam logic [DATA_WIDTH-1:0] c_dat_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] c_dat_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0]  c_acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0]  c_acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_in_ready;
  logic                   w_grad_valid;
  logic                   w_accept;
  logic                   w_grad_take;

  logic                   r_out_valid;
  logic [DATA_WIDTH-1:0]  r_dx;
  logic [DATA_WIDTH-1:0]  r_dh;
  logic [ACC_WIDTH-1:0]   r_acc [3];
  logic [COUNT_WIDTH-1:0] r_seq_len;
  logic                   r_ovf;

  logic signed [PW-1:0]   w_delta_x;
  logic [DATA_WIDTH-1:0]  w_opnd [4];
  logic signed [PW-1:0]   w_prod [4];
  logic signed [PW-1:0]   w_shift [4];
  logic [DATA_WIDTH-1:0]  w_res [2];
  logic [1:0]             w_res_ovf;
  logic [SW-1:0]          w_add [3];
  logic [ACC_WIDTH-1:0]   w_acc_nxt [3];
  logic [2:0]             w_acc_ovf;

  // Operand order: W0, W1 feed dx/dh; X, h_in feed dW0/dW1
  assign w_delta_x = {{DATA_WIDTH{bus.delta[DATA_WIDTH-1]}}, bus.delta};
  assign w_opnd[0] = bus.W0;
  assign w_opnd[1] = bus.W1;
  assign w_opnd[2] = bus.X;
  assign w_opnd[3] = bus.h_in;

  for (genvar j = 0; j < 4; j++) begin : g_prod
    logic signed [PW-1:0] w_opnd_x;
    assign w_opnd_x  = {{DATA_WIDTH{w_opnd[j][DATA_WIDTH-1]}}, w_opnd[j]};
    assign w_prod[j] = w_delta_x * w_opnd_x;
    assign w_shift[j] = w_prod[j] >>> FRACT_WIDTH;
  end

  for (genvar j = 0; j < 2; j++) begin : g_res
    logic [DATA_WIDTH-1:0] w_trunc;
    logic [PW-1:0]         w_back;
    assign w_trunc      = w_shift[j][DATA_WIDTH-1:0];
    assign w_back       = {{DATA_WIDTH{w_trunc[DATA_WIDTH-1]}}, w_trunc};
    assign w_res_ovf[j] = (w_back != w_shift[j]);
`ifdef GRAD_SAT_EN
    assign w_res[j] = !w_res_ovf[j] ? w_trunc
                    : (w_shift[j][PW-1] ? c_dat_min : c_dat_max);
`else
    assign w_res[j] = w_trunc;
`endif
  end

  assign w_add[0] = {{(SW-PW){w_shift[2][PW-1]}}, w_shift[2]};
  assign w_add[1] = {{(SW-PW){w_shift[3][PW-1]}}, w_shift[3]};
  assign w_add[2] = {{(SW-DATA_WIDTH){bus.delta[DATA_WIDTH-1]}}, bus.delta};

  for (genvar k = 0; k < 3; k++) begin : g_acc
    logic [SW-1:0]        w_sum;
    logic [SW-1:0]        w_back;
    logic [ACC_WIDTH-1:0] w_trunc;
    assign w_sum        = {{(SW-ACC_WIDTH){r_acc[k][ACC_WIDTH-1]}}, r_acc[k]} + w_add[k];
    assign w_trunc      = w_sum[ACC_WIDTH-1:0];
    assign w_back       = {{(SW-ACC_WIDTH){w_trunc[ACC_WIDTH-1]}}, w_trunc};
    assign w_acc_ovf[k] = (w_back != w_sum);
`ifdef GRAD_SAT_EN
    assign w_acc_nxt[k] = !w_acc_ovf[k] ? w_trunc
                        : (w_sum[SW-1] ? c_acc_min : c_acc_max);
`else
    assign w_acc_nxt[k] = w_trunc;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_grad_valid = 1'b0;
    case (r_state)
      RUN: begin
        w_in_ready = !r_out_valid || bus.out_ready;
        if (bus.in_valid && w_in_ready && bus.in_last) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_grad_valid = 1'b1;
        if (bus.grad_ready) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_grad_take = w_grad_valid && bus.grad_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_dx        <= '0;
      r_dh        <= '0;
      for (int k = 0; k < 3; k++) r_acc[k] <= '0;
      r_seq_len   <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_dx        <= w_res[0];
        r_dh        <= w_res[1];
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      // Accept and gradient take are mutually exclusive (RUN vs HOLD)
      if (w_grad_take) begin
        for (int k = 0; k < 3; k++) r_acc[k] <= '0;
        r_seq_len <= '0;
        r_ovf     <= 1'b0;
      end else if (w_accept) begin
        for (int k = 0; k < 3; k++) r_acc[k] <= w_acc_nxt[k];
        if (r_seq_len != {COUNT_WIDTH{1'b1}}) begin
          r_seq_len <= r_seq_len + COUNT_WIDTH'(1);
        end
        if ((|w_res_ovf) || (|w_acc_ovf)) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.dx         = r_dx;
  assign bus.dh         = r_dh;
  assign bus.grad_valid = w_grad_valid;
  assign bus.dW0        = r_acc[0];
  assign bus.dW1        = r_acc[1];
  assign bus.db         = r_acc[2];
  assign bus.seq_len    = r_seq_len;
  assign bus.ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_concat_mult_add_grad.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_concat_mult_add_grad                                |
// | Brief   : Scoreboard bench for concat_mult_add_grad              |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_concat_mult_add_grad;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam longint C_AMAX = 64'sd2147483647;
  localparam longint C_AMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  concat_mult_add_grad_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

  concat_mult_add_grad #(
    .DATA_WIDTH(DW), .FRACT_WIDTH(FW), .ACC_WIDTH(AW), .COUNT_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [AW-1:0] dw0;
    logic [AW-1:0] dw1;
    logic [AW-1:0] db;
    logic [CW-1:0] len;
    logic          ovf;
  } grad_t;

  logic [2*DW-1:0]        q_out [$];
  grad_t                  q_grad [$];
  logic signed [AW-1:0]   m_acc [3];
  logic [CW-1:0]          m_len;
  bit                     m_ovf;
  int                     checks = 0;
  int                     errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] fx_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           output bit ov);
    int p;
    logic [31:0] pv;
    p  = (int'($signed(a)) * int'($signed(b))) >>> FW;
    ov = (p > 32767) || (p < -32768);
`ifdef GRAD_SAT_EN
    if (p > 32767)  return 16'h7FFF;
    if (p < -32768) return 16'h8000;
`endif
    pv = p;
    return pv[DW-1:0];
  endfunction

  function automatic logic signed [AW-1:0] acc_add(input logic signed [AW-1:0] a,
                                                   input longint v, output bit ov);
    longint s;
    logic [63:0] sv;
    s  = longint'(a) + v;
    ov = (s > C_AMAX) || (s < C_AMIN);
`ifdef GRAD_SAT_EN
    if (s > C_AMAX) return 32'sh7FFFFFFF;
    if (s < C_AMIN) return 32'sh80000000;
`endif
    sv = s;
    return sv[AW-1:0];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) m_acc[k] = '0;
    m_len = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_accept();
    bit o0, o1, o2, o3, o4;
    logic [DW-1:0] edx, edh;
    int p2, p3;
    grad_t g;
    edx = fx_mul(bus.delta, bus.W0, o0);
    edh = fx_mul(bus.delta, bus.W1, o1);
    q_out.push_back({edx, edh});
    p2 = (int'($signed(bus.delta)) * int'($signed(bus.X))) >>> FW;
    p3 = (int'($signed(bus.delta)) * int'($signed(bus.h_in))) >>> FW;
    m_acc[0] = acc_add(m_acc[0], longint'(p2), o2);
    m_acc[1] = acc_add(m_acc[1], longint'(p3), o3);
    m_acc[2] = acc_add(m_acc[2], longint'(int'($signed(bus.delta))), o4);
    if (m_len != '1) m_len = m_len + 16'd1;
    m_ovf = m_ovf | o0 | o1 | o2 | o3 | o4;
    if (bus.in_last) begin
      g.dw0 = m_acc[0];
      g.dw1 = m_acc[1];
      g.db  = m_acc[2];
      g.len = m_len;
      g.ovf = m_ovf;
      q_grad.push_back(g);
      model_clear();
    end
  endtask

  // Monitor: compare presented data against queue heads, pop on handshake, push on accept
  always @(negedge clk) begin : mon
    logic [2*DW-1:0] eo;
    grad_t eg;
    if (!rst_n) begin
      q_out.delete();
      q_grad.delete();
      model_clear();
    end else begin
      if (bus.out_valid) begin
        if (q_out.size() == 0) begin
          check("out_unexpected", 1, 0);
        end else begin
          eo = q_out[0];
          check("sb_dx", bus.dx, eo[2*DW-1:DW]);
          check("sb_dh", bus.dh, eo[DW-1:0]);
          if (bus.out_ready) void'(q_out.pop_front());
        end
      end
      if (bus.grad_valid) begin
        if (q_grad.size() == 0) begin
          check("grad_unexpected", 1, 0);
        end else begin
          eg = q_grad[0];
          check("sb_dW0", bus.dW0, eg.dw0);
          check("sb_dW1", bus.dW1, eg.dw1);
          check("sb_db", bus.db, eg.db);
          check("sb_seq_len", bus.seq_len, eg.len);
          check("sb_ovf", bus.ovf, eg.ovf);
          if (bus.grad_ready) void'(q_grad.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) model_accept();
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] x, input logic [DW-1:0] h,
                      input logic [DW-1:0] w0, input logic [DW-1:0] w1, input bit last,
                      output int cyc);
    bit ok;
    ok  = 1'b0;
    cyc = 0;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.delta    = d;
    bus.X        = x;
    bus.h_in     = h;
    bus.W0       = w0;
    bus.W1       = w1;
    while (!ok && cyc < 40) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic take_grad();
    int n;
    n = 0;
    while (!bus.grad_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.grad_valid) check("grad_timeout", 0, 1);
    bus.grad_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.grad_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int cyc;
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.delta      = '0;
    bus.X          = '0;
    bus.h_in       = '0;
    bus.W0         = '0;
    bus.W1         = '0;
    bus.out_ready  = 1'b1;
    bus.grad_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_grad_valid", bus.grad_valid, 0);
    check("rst_dx", bus.dx, 0);
    check("rst_dW0", bus.dW0, 0);
    check("rst_seq_len", bus.seq_len, 0);
    check("rst_ovf", bus.ovf, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("run_in_ready", bus.in_ready, 1);

    // Single-sample sequence
    send(16'h0200, 16'h0300, 16'h0100, 16'h0080, 16'hFF00, 1'b1, cyc);
    @(negedge clk);
    check("t1_dx", bus.dx, 16'h0100);
    check("t1_dh", bus.dh, 16'hFE00);
    check("t1_grad_valid", bus.grad_valid, 1);
    check("t1_dW0", bus.dW0, 32'h600);
    check("t1_dW1", bus.dW1, 32'h200);
    check("t1_db", bus.db, 32'h200);
    check("t1_seq_len", bus.seq_len, 1);
    check("t1_ovf", bus.ovf, 0);
    check("t1_hold_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    take_grad();

    // Four back-to-back samples
    for (int i = 0; i < 4; i++) begin
      send(16'h0200, 16'h0300, 16'h0100, 16'h0080, 16'hFF00, (i == 3), cyc);
      check("t2_no_bubble", cyc, 1);
    end
    @(negedge clk);
    check("t2_dW0", bus.dW0, 32'h1800);
    check("t2_dW1", bus.dW1, 32'h0800);
    check("t2_db", bus.db, 32'h0800);
    check("t2_seq_len", bus.seq_len, 4);
    @(posedge clk);
    #1;
    take_grad();
    @(negedge clk);
    check("t2_clr_dW0", bus.dW0, 0);
    check("t2_clr_dW1", bus.dW1, 0);
    check("t2_clr_db", bus.db, 0);
    check("t2_clr_seq_len", bus.seq_len, 0);
    check("t2_clr_grad_valid", bus.grad_valid, 0);
    check("t2_ready_after_grad", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Backpressure on the output slot
    bus.out_ready = 1'b0;
    send(16'h0200, 16'h0300, 16'h0100, 16'h0080, 16'hFF00, 1'b0, cyc);
    check("t3_first_accept", cyc, 1);
    bus.in_valid = 1'b1;
    bus.delta    = 16'h0100;
    bus.X        = 16'h0100;
    bus.h_in     = 16'h0200;
    bus.W0       = 16'h0100;
    bus.W1       = 16'h0100;
    repeat (3) begin
      @(negedge clk);
      check("t3_stall_in_ready", bus.in_ready, 0);
      check("t3_stall_dx", bus.dx, 16'h0100);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(16'h0100, 16'h0100, 16'h0200, 16'h0100, 16'h0100, 1'b1, cyc);
    check("t3_release", cyc, 1);

    // HOLD blocks new samples until gradients are taken
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t4_in_ready", bus.in_ready, 0);
      check("t4_dW0", bus.dW0, 32'h700);
      check("t4_dW1", bus.dW1, 32'h400);
      check("t4_db", bus.db, 32'h300);
      check("t4_seq_len", bus.seq_len, 2);
      @(posedge clk);
      #1;
    end
    bus.in_valid   = 1'b0;
    bus.grad_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.grad_ready = 1'b0;
    @(negedge clk);
    check("t4_ready_after", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Product overflow on dx
    send(16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, cyc);
    @(negedge clk);
`ifdef GRAD_SAT_EN
    check("t5_dx", bus.dx, 16'h7FFF);
`else
    check("t5_dx", bus.dx, 16'hFF00);
`endif
    check("t5_ovf", bus.ovf, 1);
    @(posedge clk);
    #1;
    take_grad();

    // Reset in the middle of a sequence
    send(16'h0200, 16'h0300, 16'h0100, 16'h0080, 16'hFF00, 1'b0, cyc);
    send(16'h0200, 16'h0300, 16'h0100, 16'h0080, 16'hFF00, 1'b0, cyc);
    rst_n = 1'b0;
    #2;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_dx", bus.dx, 0);
    check("t6_dh", bus.dh, 0);
    check("t6_grad_valid", bus.grad_valid, 0);
    check("t6_dW0", bus.dW0, 0);
    check("t6_dW1", bus.dW1, 0);
    check("t6_db", bus.db, 0);
    check("t6_seq_len", bus.seq_len, 0);
    check("t6_ovf", bus.ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'h0200, 16'h0300, 16'h0100, 16'h0080, 16'hFF00, 1'b1, cyc);
    @(negedge clk);
    check("t6_new_seq_len", bus.seq_len, 1);
    check("t6_new_dW0", bus.dW0, 32'h600);
    @(posedge clk);
    #1;
    take_grad();

    repeat (3) @(posedge clk);
    #1;
    check("sb_out_empty", q_out.size(), 0);
    check("sb_grad_empty", q_grad.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
